// File: rtl/instruction_fetch_pkg.sv
// Shared FSM encoding and default widths for the instruction fetch controller.
// No logic; imported by the controller and its prefetch FIFO.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 11;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO, DEPTH x WIDTH; output registered, one cycle push-to-pop, no bypass.
// Push is refused when full unless a pop happens in the same cycle; pop_data reads 0 while empty.
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH,
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear && !reset) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_ctrl.sv
// Fetches num_inst words from base_addr into a prefetch FIFO; first word valid 3 cycles after start.
// Reads are credit-limited by FIFO space, so decoder backpressure stalls fetching. Optional IFETCH_STALL_CNT_EN adds stall_count.
module instruction_fetch_ctrl
  import instruction_fetch_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   num_inst,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  imem_read_req,
  output logic [ADDR_WIDTH-1:0] imem_read_addr,
  input  logic [DATA_WIDTH-1:0] imem_read_data,
  output logic [DATA_WIDTH-1:0] inst_data,
  output logic                  inst_valid,
  input  logic                  inst_ready
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0]           stall_count
`endif
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   reads_left;
  logic [ADDR_WIDTH:0]   xfers_left;
  logic                  in_flight;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [FCW:0]          occupancy;
  logic                  kill;
  logic                  accept;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Reset mid-sequence behaves like flush and both override everything else.
  assign kill      = reset || flush;
  assign accept    = (state == S_IDLE) && start && !kill;
  assign occupancy = {1'b0, fifo_count} + (FCW + 1)'(in_flight);
  assign issue     = (state == S_FETCH) && !kill && !fifo_full &&
                     (occupancy < (FCW + 1)'(FIFO_DEPTH));
  assign push      = in_flight && !kill;
  assign inst_valid = !fifo_empty;
  assign pop       = inst_valid && inst_ready && !kill;
  assign imem_read_addr = addr_q;

  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    imem_read_req = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (num_inst == '0) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        busy          = 1'b1;
        imem_read_req = issue;
        if (issue && reads_left == (ADDR_WIDTH + 1)'(1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (pop && xfers_left == (ADDR_WIDTH + 1)'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = !kill;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      reads_left <= '0;
      xfers_left <= '0;
      in_flight  <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= issue;
      if (accept) begin
        addr_q     <= base_addr;
        reads_left <= num_inst;
        xfers_left <= num_inst;
      end else begin
        if (issue) begin
          addr_q     <= addr_q + ADDR_WIDTH'(1);
          reads_left <= reads_left - (ADDR_WIDTH + 1)'(1);
        end
        if (pop) xfers_left <= xfers_left - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Data returning for a read issued just before a flush lands in the flush cycle and is dropped.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH),
    .CW    (FCW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (imem_read_data),
    .pop       (pop),
    .pop_data  (inst_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifdef IFETCH_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset || accept) begin
      stall_count <= '0;
    end else if (busy && inst_valid && !inst_ready && stall_count != '1) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Scoreboarded bench for instruction_fetch_ctrl: expected addresses/words queued at start, checked as reads and transfers appear.
module tb_instruction_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, flush, inst_ready;
  logic [10:0] base_addr, imem_read_addr;
  logic [11:0] num_inst;
  logic        busy, done, imem_read_req, inst_valid;
  logic [31:0] imem_read_data, inst_data;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_count;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [10:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  instruction_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_inst       (num_inst),
    .flush          (flush),
    .busy           (busy),
    .done           (done),
    .imem_read_req  (imem_read_req),
    .imem_read_addr (imem_read_addr),
    .imem_read_data (imem_read_data),
    .inst_data      (inst_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [10:0] a);
    return {16'hC0DE, 5'd0, a};
  endfunction

  // Instruction memory: data for a read seen in cycle k appears at the start of cycle k+1.
  initial begin
    logic        rq;
    logic [10:0] ra;
    imem_read_data = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      rq = imem_read_req;
      ra = imem_read_addr;
      @(posedge clk);
      #1;
      imem_read_data = (rq === 1'b1) ? mem_word(ra) : 32'hBAD0_BAD0;
    end
  end

  // Scoreboard monitor: read addresses, delivered words, and hold-under-stall.
  initial begin
    logic        hold_chk;
    logic [31:0] held;
    logic [10:0] ea;
    logic [31:0] ed;
    hold_chk = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (imem_read_req === 1'b1) begin
        n_cmp++;
        if (exp_addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_addr: unexpected read of %h, none expected", imem_read_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (imem_read_addr !== ea) begin
            n_fail++;
            $display("FAIL rd_addr: got %h expected %h", imem_read_addr, ea);
          end
        end
      end
      if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
        n_cmp++;
        if (exp_data_q.size() == 0) begin
          n_fail++;
          $display("FAIL inst_data: unexpected word %h, none expected", inst_data);
        end else begin
          ed = exp_data_q.pop_front();
          if (inst_data !== ed) begin
            n_fail++;
            $display("FAIL inst_data: got %h expected %h", inst_data, ed);
          end
        end
      end
      if (hold_chk) begin
        n_cmp++;
        if (inst_valid !== 1'b1 || inst_data !== held) begin
          n_fail++;
          $display("FAIL hold: got valid=%b data=%h expected valid=1 data=%h", inst_valid, inst_data, held);
        end
      end
      hold_chk = (inst_valid === 1'b1) && !inst_ready && !flush && !reset;
      held     = inst_data;
    end
  end

  // Drives a one-cycle start in cycle 0; returns at the start of cycle 1.
  task automatic pulse_start(input logic [10:0] base, input logic [11:0] n);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = base;
    num_inst = n;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(base + 11'(i));
      exp_data_q.push_back(mem_word(base + 11'(i)));
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; inst_ready = 1'b0;
    base_addr = '0; num_inst = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    n_cmp++; if (imem_read_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b expected 0", imem_read_req); end
    n_cmp++; if (imem_read_addr !== 11'h000) begin n_fail++; $display("FAIL rst_addr: got %h expected 000", imem_read_addr); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
    n_cmp++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 0", inst_data); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int reads = 0, xfers = 0, dones = 0, first_rd = -1, last_rd = -1, last_x = -1, done_c = -1;
    logic busy1 = 1'b0;
    inst_ready = 1'b1;
    pulse_start(11'h010, 12'd5);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) busy1 = busy;
      if (imem_read_req === 1'b1) begin reads++; if (first_rd < 0) first_rd = c; last_rd = c; end
      if (inst_valid === 1'b1 && inst_ready) begin xfers++; last_x = c; end
      if (done === 1'b1) begin dones++; done_c = c; end
      @(posedge clk); #1;
    end
    n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b expected 1", busy1); end
    n_cmp++; if (reads != 5) begin n_fail++; $display("FAIL basic_reads: got %0d expected 5", reads); end
    n_cmp++; if (first_rd != 1 || last_rd != 5) begin n_fail++; $display("FAIL basic_rd_cycles: got %0d..%0d expected 1..5", first_rd, last_rd); end
    n_cmp++; if (xfers != 5 || last_x != 7) begin n_fail++; $display("FAIL basic_xfers: got %0d last c%0d expected 5 last c7", xfers, last_x); end
    n_cmp++; if (dones != 1 || done_c != 8) begin n_fail++; $display("FAIL basic_done: got %0d at c%0d expected 1 at c8", dones, done_c); end
  endtask

  task automatic test_backpressure();
    int reads = 0, xfers = 0;
    logic seen = 1'b0;
    inst_ready = 1'b0;
    pulse_start(11'h040, 12'd10);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (imem_read_req === 1'b1) reads++;
      @(posedge clk); #1;
    end
    n_cmp++; if (reads != 4) begin n_fail++; $display("FAIL bp_stall_reads: got %0d expected 4", reads); end
    n_cmp++; if (inst_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL bp_stalled: got valid=%b busy=%b expected 1 1", inst_valid, busy); end
    inst_ready = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (imem_read_req === 1'b1) reads++;
      if (inst_valid === 1'b1) xfers++;
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL bp_done: got no done expected done within 60 cycles"); end
    n_cmp++; if (reads != 10 || xfers != 10) begin n_fail++; $display("FAIL bp_totals: got %0d reads %0d words expected 10 10", reads, xfers); end
  endtask

  task automatic test_wrap();
    logic [10:0] want [4];
    logic [10:0] got [4];
    int k = 0;
    logic seen = 1'b0;
    want[0] = 11'h7FE; want[1] = 11'h7FF; want[2] = 11'h000; want[3] = 11'h001;
    inst_ready = 1'b1;
    pulse_start(11'h7FE, 12'd4);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (imem_read_req === 1'b1 && k < 4) begin got[k] = imem_read_addr; k++; end
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (k != 4 || !seen) begin n_fail++; $display("FAIL wrap_count: got %0d reads done=%b expected 4 reads done=1", k, seen); end
    for (int i = 0; i < k; i++) begin
      n_cmp++;
      if (got[i] !== want[i]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h expected %h", i, got[i], want[i]); end
    end
  endtask

  task automatic test_zero();
    int reads = 0, dones = 0, busies = 0, done_c = -1;
    pulse_start(11'h123, 12'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (imem_read_req === 1'b1) reads++;
      if (busy === 1'b1) busies++;
      if (done === 1'b1) begin dones++; done_c = c; end
      @(posedge clk); #1;
    end
    n_cmp++; if (reads != 0) begin n_fail++; $display("FAIL zero_reads: got %0d expected 0", reads); end
    n_cmp++; if (dones != 1 || done_c != 1) begin n_fail++; $display("FAIL zero_done: got %0d at c%0d expected 1 at c1", dones, done_c); end
    n_cmp++; if (busies != 0) begin n_fail++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busies); end
  endtask

  task automatic test_flush();
    int reads = 0, dones = 0, valids = 0, xfers = 0;
    logic seen = 1'b0;
    inst_ready = 1'b0;
    pulse_start(11'h200, 12'd8);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (imem_read_req === 1'b1) reads++;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (reads != 3) begin n_fail++; $display("FAIL flush_reads: got %0d expected 3", reads); end
    n_cmp++; if (inst_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_clear: got valid=%b busy=%b expected 0 0", inst_valid, busy); end
    for (int c = 0; c < 8; c++) begin
      if (done === 1'b1) dones++;
      if (inst_valid === 1'b1 || imem_read_req === 1'b1) valids++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    n_cmp++; if (dones != 0 || valids != 0) begin n_fail++; $display("FAIL flush_quiet: got %0d dones %0d active expected 0 0", dones, valids); end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    pulse_start(11'h300, 12'd3);
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (inst_valid === 1'b1) xfers++;
      if (done === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++; if (!seen || xfers != 3) begin n_fail++; $display("FAIL flush_restart: got done=%b words=%0d expected 1 3", seen, xfers); end
  endtask

  task automatic test_reset_mid();
    inst_ready = 1'b0;
    pulse_start(11'h050, 12'd6);
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    reset = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || imem_read_req !== 1'b0 || inst_valid !== 1'b0 || imem_read_addr !== 11'h000) begin
      n_fail++;
      $display("FAIL midrst: got busy=%b req=%b valid=%b addr=%h expected 0 0 0 000", busy, imem_read_req, inst_valid, imem_read_addr);
    end
    @(posedge clk); #1;
  endtask

`ifdef IFETCH_STALL_CNT_EN
  task automatic test_stall_count();
    logic seen = 1'b0;
    logic [31:0] at_done = '0;
    inst_ready = 1'b0;
    pulse_start(11'h0A0, 12'd2);
    for (int c = 1; c <= 30 && !seen; c++) begin
      inst_ready = (c >= 10);
      @(negedge clk);
      if (done === 1'b1) begin seen = 1'b1; at_done = stall_count; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!seen || at_done !== 32'd7) begin n_fail++; $display("FAIL stall_count: got %0d done=%b expected 7 done=1", at_done, seen); end
    @(negedge clk);
    n_cmp++; if (stall_count !== 32'd7) begin n_fail++; $display("FAIL stall_hold: got %0d expected 7", stall_count); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_flush();
    test_reset_mid();
`ifdef IFETCH_STALL_CNT_EN
    test_stall_count();
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d reads %0d words pending expected 0 0", exp_addr_q.size(), exp_data_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
